// File: rtl/execute_md.sv
// execute_md: MIPS execute stage with forwarding, branch resolution, iterative mul/div with HI/LO and EX/MEM register
module execute_md #(
    parameter int DATA_W = 32,
    parameter int PC_W = 11,
    parameter int REG_W = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [3:0]                alu_ctrl,
    input  logic [2:0]                md_op,
    input  logic [1:0]                hilo_rd,
    input  logic                      ALUSrc,
    input  logic                      RegDst,
    input  logic [1:0]                ForwardA,
    input  logic [1:0]                ForwardB,
    input  logic [DATA_W-1:0]         registro_1,
    input  logic [DATA_W-1:0]         registro_2,
    input  logic [DATA_W-1:0]         sign_extend,
    input  logic [DATA_W-1:0]         memory_mem_wb,
    input  logic [$clog2(DATA_W)-1:0] sa,
    input  logic [REG_W-1:0]          reg_dest_r_type,
    input  logic [REG_W-1:0]          reg_dest_l_type,
    input  logic [PC_W-1:0]           current_pc,
    input  logic [PC_W-1:0]           branch_dest_addr,
    input  logic [1:0]                sel_dire_salto,
    input  logic                      Branch_in,
    input  logic                      Bne_in,
    input  logic                      Jump_in,
    input  logic                      MemToReg_in,
    input  logic                      RegWrite_in,
    input  logic                      MemRead_in,
    input  logic                      MemWrite_in,
    input  logic [2:0]                trunk_mode_in,
    input  logic                      flush,
    output logic [DATA_W-1:0]         result_out,
    output logic [DATA_W-1:0]         registro_2_out,
    output logic [REG_W-1:0]          reg_dest_out,
    output logic                      MemToReg_out,
    output logic                      RegWrite_out,
    output logic                      MemRead_out,
    output logic                      MemWrite_out,
    output logic [2:0]                trunk_mode_out,
    output logic                      PCSrc,
    output logic [PC_W-1:0]           PC_salto,
    output logic                      md_busy,
    output logic                      md_stall
);
    localparam int SW = $clog2(DATA_W);

    logic [DATA_W-1:0] a, bf, b, alu, hi, lo, p_hi, p_lo, m, dvd, ma, mb, nx_hi, nx_lo, res_hi, res_lo;
    logic [DATA_W:0] sum, sh;
    logic [2*DATA_W-1:0] prod;
    logic [SW-1:0] cnt;
    logic is_div, neg_q, neg_r, dz, sgn, div_op, a_s, b_s, ge, start, mt_ok, bubble, last;

    always_comb begin
        a = ForwardA == 2'b01 ? result_out : ForwardA == 2'b10 ? memory_mem_wb : registro_1;
        bf = ForwardB == 2'b01 ? result_out : ForwardB == 2'b10 ? memory_mem_wb : registro_2;
        b = ALUSrc ? sign_extend : bf;
        case (alu_ctrl)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a & b;
            4'd3:    alu = a | b;
            4'd4:    alu = a ^ b;
            4'd5:    alu = ~(a | b);
            4'd6:    alu = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            4'd7:    alu = {{(DATA_W-1){1'b0}}, a < b};
            4'd8:    alu = b << sa;
            4'd9:    alu = b >> sa;
            4'd10:   alu = $signed(b) >>> sa;
            4'd11:   alu = b << a[SW-1:0];
            4'd12:   alu = b >> a[SW-1:0];
            4'd13:   alu = $signed(b) >>> a[SW-1:0];
            4'd14:   alu = b << (DATA_W / 2);
            default: alu = DATA_W'(current_pc + PC_W'(1));
        endcase
    end

    assign PCSrc = (Branch_in && a == bf) || (Bne_in && a != bf) || Jump_in;
    assign PC_salto = sel_dire_salto == 2'b00 ? branch_dest_addr :
                      sel_dire_salto == 2'b01 ? sign_extend[PC_W-1:0] : a[PC_W-1:0];

    assign md_stall = md_busy && ((md_op != 3'd0 && md_op != 3'd7) || hilo_rd == 2'b01 || hilo_rd == 2'b10);
    assign bubble = flush || md_stall;
    assign start = md_op >= 3'd1 && md_op <= 3'd4 && !md_busy && !flush && !reset;
    assign mt_ok = (md_op == 3'd5 || md_op == 3'd6) && !bubble && !reset;

    // Operands are reduced to magnitudes at start; signs are re-applied on the final step.
    always_comb begin
        sgn = md_op == 3'd1 || md_op == 3'd3;
        div_op = md_op == 3'd3 || md_op == 3'd4;
        a_s = sgn && a[DATA_W-1];
        b_s = sgn && bf[DATA_W-1];
        ma = a_s ? -a : a;
        mb = b_s ? -bf : bf;
        sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);
        sh = {p_hi, p_lo[DATA_W-1]};
        ge = sh >= {1'b0, m};
        nx_hi = is_div ? (ge ? DATA_W'(sh - {1'b0, m}) : sh[DATA_W-1:0]) : sum[DATA_W:1];
        nx_lo = is_div ? {p_lo[DATA_W-2:0], ge} : {sum[0], p_lo[DATA_W-1:1]};
        prod = neg_q ? -{nx_hi, nx_lo} : {nx_hi, nx_lo};
        res_hi = is_div ? (dz ? dvd : neg_r ? -nx_hi : nx_hi) : prod[2*DATA_W-1:DATA_W];
        res_lo = is_div ? (dz ? '1 : neg_q ? -nx_lo : nx_lo) : prod[DATA_W-1:0];
        last = cnt == SW'(DATA_W - 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            md_busy <= 1'b0;
            cnt <= '0;
            p_hi <= '0;
            p_lo <= '0;
            m <= '0;
            dvd <= '0;
            is_div <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
        end else begin
            if (start) begin
                md_busy <= 1'b1;
                cnt <= '0;
                is_div <= div_op;
                neg_q <= a_s ^ b_s;
                neg_r <= a_s;
                dz <= bf == '0;
                dvd <= a;
                p_hi <= '0;
                p_lo <= div_op ? ma : mb;
                m <= div_op ? mb : ma;
            end else if (md_busy) begin
                p_hi <= nx_hi;
                p_lo <= nx_lo;
                cnt <= cnt + SW'(1);
                if (last) begin
                    md_busy <= 1'b0;
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
            if (mt_ok && md_op == 3'd5) hi <= a;
            if (mt_ok && md_op == 3'd6) lo <= a;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || bubble) begin
            result_out <= '0;
            registro_2_out <= '0;
            reg_dest_out <= '0;
            MemToReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
            MemRead_out <= 1'b0;
            MemWrite_out <= 1'b0;
            trunk_mode_out <= '0;
        end else begin
            result_out <= hilo_rd == 2'b01 ? hi : hilo_rd == 2'b10 ? lo : alu;
            registro_2_out <= bf;
            reg_dest_out <= RegDst ? reg_dest_r_type : reg_dest_l_type;
            MemToReg_out <= MemToReg_in;
            RegWrite_out <= RegWrite_in;
            MemRead_out <= MemRead_in;
            MemWrite_out <= MemWrite_in;
            trunk_mode_out <= trunk_mode_in;
        end
    end
endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: randomized self-checking bench for execute_md against a behavioural model
module tb_execute_md;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    logic [3:0] alu_ctrl;
    logic [2:0] md_op;
    logic [1:0] hilo_rd, ForwardA, ForwardB, sel_dire_salto;
    logic ALUSrc, RegDst, Branch_in, Bne_in, Jump_in, flush;
    logic MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in;
    logic [2:0] trunk_mode_in;
    logic [W-1:0] registro_1, registro_2, sign_extend, memory_mem_wb;
    logic [4:0] sa, reg_dest_r_type, reg_dest_l_type;
    logic [10:0] current_pc, branch_dest_addr;
    logic [W-1:0] result_out, registro_2_out;
    logic [4:0] reg_dest_out;
    logic MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, PCSrc, md_busy, md_stall;
    logic [2:0] trunk_mode_out;
    logic [10:0] PC_salto;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, exp_res = '0;

    execute_md dut (
        .clock(clock), .reset(reset), .alu_ctrl(alu_ctrl), .md_op(md_op), .hilo_rd(hilo_rd),
        .ALUSrc(ALUSrc), .RegDst(RegDst), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .registro_1(registro_1), .registro_2(registro_2), .sign_extend(sign_extend),
        .memory_mem_wb(memory_mem_wb), .sa(sa), .reg_dest_r_type(reg_dest_r_type),
        .reg_dest_l_type(reg_dest_l_type), .current_pc(current_pc),
        .branch_dest_addr(branch_dest_addr), .sel_dire_salto(sel_dire_salto),
        .Branch_in(Branch_in), .Bne_in(Bne_in), .Jump_in(Jump_in),
        .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .trunk_mode_in(trunk_mode_in), .flush(flush),
        .result_out(result_out), .registro_2_out(registro_2_out), .reg_dest_out(reg_dest_out),
        .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .trunk_mode_out(trunk_mode_out), .PCSrc(PCSrc),
        .PC_salto(PC_salto), .md_busy(md_busy), .md_stall(md_stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_ctrl = '0; md_op = '0; hilo_rd = '0; ALUSrc = 0; RegDst = 0;
        ForwardA = '0; ForwardB = '0; sel_dire_salto = '0;
        Branch_in = 0; Bne_in = 0; Jump_in = 0; flush = 0;
        MemToReg_in = 0; RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; trunk_mode_in = '0;
        registro_1 = '0; registro_2 = '0; sign_extend = '0; memory_mem_wb = '0;
        sa = '0; reg_dest_r_type = '0; reg_dest_l_type = '0; current_pc = '0; branch_dest_addr = '0;
    endtask

    function automatic logic [W-1:0] sra(input logic [W-1:0] y, input logic [4:0] s);
        return (y >> s) | (y[W-1] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
    endfunction

    function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] x, y,
                                             input logic [4:0] s, input logic [10:0] pc);
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return ~(x | y);
            4'd6: return {31'b0, $signed(x) < $signed(y)};
            4'd7: return {31'b0, x < y};
            4'd8: return y << s;
            4'd9: return y >> s;
            4'd10: return sra(y, s);
            4'd11: return y << x[4:0];
            4'd12: return y >> x[4:0];
            4'd13: return sra(y, x[4:0]);
            4'd14: return y * 32'd65536;
            default: return {21'b0, pc + 11'd1};
        endcase
    endfunction

    task automatic md_ref(input logic [2:0] op, input logic [W-1:0] x, y,
                          output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = (op == 3'd1 || op == 3'd3) ? longint'($signed(x)) : longint'({32'b0, x});
        sy = (op == 3'd1 || op == 3'd3) ? longint'($signed(y)) : longint'({32'b0, y});
        if (op <= 3'd2) begin
            p = sx * sy;
            rh = p[63:32];
            rl = p[31:0];
        end else if (y == '0) begin
            rh = x;
            rl = '1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            p = q;
            rl = p[31:0];
            p = r;
            rh = p[31:0];
        end
    endtask

    task automatic md_run(input logic [2:0] op, input logic [W-1:0] x, y, eh, el);
        int n;
        idle();
        md_op = op; registro_1 = x; registro_2 = y;
        #1;
        check("md_start_stall", md_stall, 0);
        tick();
        check("md_busy_set", md_busy, 1);
        m_hi = eh;
        m_lo = el;
        idle();
        hilo_rd = 2'b01; RegWrite_in = 1;
        #1;
        n = 0;
        while (md_stall && n < 100) begin
            n++;
            tick();
            if (n == 1) check("md_bubble_regwrite", {RegWrite_out, result_out}, 0);
        end
        check("md_stall_len", n, W);
        check("md_busy_fell", md_busy, 0);
        tick();
        check("mfhi", result_out, m_hi);
        hilo_rd = 2'b10;
        tick();
        check("mflo", result_out, m_lo);
        check("mflo_regwrite", RegWrite_out, 1);
        exp_res = m_lo;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ea, ebf, eb, e, rh, rl, x, y;
        logic [2:0] op;
        int n;
        idle();
        reset = 1;
        RegWrite_in = 1; MemRead_in = 1; trunk_mode_in = 3'd5; registro_1 = 32'd77;
        tick();
        tick();
        check("rst_result", result_out, 0);
        check("rst_reg2", registro_2_out, 0);
        check("rst_ctrl", {reg_dest_out, MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out,
                           trunk_mode_out, md_busy}, 0);
        reset = 0;

        idle();
        registro_1 = 32'd3; registro_2 = 32'd4; RegWrite_in = 1;
        tick();
        check("add_base", result_out, 7);
        registro_1 = 32'd5; registro_2 = 32'd99; ForwardB = 2'b01;
        tick();
        check("add_fwd", result_out, 12);
        check("add_regwrite", RegWrite_out, 1);
        exp_res = 32'd12;

        for (int i = 0; i < 40; i++) begin
            alu_ctrl = 4'($urandom_range(0, 15));
            md_op = $urandom_range(0, 1) ? 3'd0 : 3'd7;
            hilo_rd = $urandom_range(0, 1) ? 2'b00 : 2'b11;
            ForwardA = 2'($urandom_range(0, 3));
            ForwardB = 2'($urandom_range(0, 3));
            ALUSrc = 1'($urandom_range(0, 1));
            RegDst = 1'($urandom_range(0, 1));
            registro_1 = $urandom; registro_2 = $urandom;
            sign_extend = $urandom; memory_mem_wb = $urandom;
            if (i % 4 == 0) begin
                registro_2 = registro_1; ForwardA = 2'b00; ForwardB = 2'b00;
            end
            sa = 5'($urandom); reg_dest_r_type = 5'($urandom); reg_dest_l_type = 5'($urandom);
            current_pc = 11'($urandom); branch_dest_addr = 11'($urandom);
            sel_dire_salto = 2'($urandom_range(0, 3));
            Branch_in = 1'($urandom_range(0, 1)); Bne_in = 1'($urandom_range(0, 1));
            Jump_in = ($urandom_range(0, 3) == 0);
            MemToReg_in = 1'($urandom_range(0, 1)); RegWrite_in = 1'($urandom_range(0, 1));
            MemRead_in = 1'($urandom_range(0, 1)); MemWrite_in = 1'($urandom_range(0, 1));
            trunk_mode_in = 3'($urandom_range(0, 7));
            ea = ForwardA == 2'b01 ? exp_res : ForwardA == 2'b10 ? memory_mem_wb : registro_1;
            ebf = ForwardB == 2'b01 ? exp_res : ForwardB == 2'b10 ? memory_mem_wb : registro_2;
            eb = ALUSrc ? sign_extend : ebf;
            e = alu_ref(alu_ctrl, ea, eb, sa, current_pc);
            #1;
            check("pcsrc", PCSrc, (Branch_in && ea == ebf) || (Bne_in && ea != ebf) || Jump_in);
            check("pc_salto", PC_salto, sel_dire_salto == 2'b00 ? branch_dest_addr :
                                        sel_dire_salto == 2'b01 ? sign_extend[10:0] : ea[10:0]);
            check("idle_stall", md_stall, 0);
            tick();
            check($sformatf("alu_op%0d", alu_ctrl), result_out, e);
            check("reg2_out", registro_2_out, ebf);
            check("reg_dest", reg_dest_out, RegDst ? reg_dest_r_type : reg_dest_l_type);
            check("ctrl_out", {MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, trunk_mode_out},
                  {MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, trunk_mode_in});
            exp_res = e;
        end

        md_run(3'd1, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        md_run(3'd3, 32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD);
        md_run(3'd4, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
        md_run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(1, 4));
            x = $urandom;
            y = (i == 5) ? 32'd0 : (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i == 3) x = -32'sd12345;
            md_ref(op, x, y, rh, rl);
            md_run(op, x, y, rh, rl);
        end

        idle();
        x = $urandom; y = $urandom;
        md_op = 3'd5; registro_1 = x;
        tick();
        md_op = 3'd6; registro_1 = y;
        tick();
        md_op = 3'd0; hilo_rd = 2'b01;
        tick();
        check("mthi", result_out, x);
        hilo_rd = 2'b10;
        tick();
        check("mtlo", result_out, y);
        m_hi = x; m_lo = y;

        idle();
        registro_1 = 32'd4; registro_2 = 32'd4; Bne_in = 1;
        #1;
        check("bne_equal", PCSrc, 0);
        Bne_in = 0; Branch_in = 1; branch_dest_addr = 11'h2A5;
        #1;
        check("beq_pcsrc", PCSrc, 1);
        check("beq_target", PC_salto, 11'h2A5);
        Branch_in = 0; Jump_in = 1; sel_dire_salto = 2'b10; registro_1 = 32'h123;
        #1;
        check("jr_pcsrc", PCSrc, 1);
        check("jr_target", PC_salto, 11'h123);

        idle();
        md_op = 3'd1; flush = 1; registro_1 = 32'd1000; registro_2 = 32'd1000; RegWrite_in = 1;
        tick();
        check("flush_no_busy", md_busy, 0);
        check("flush_bubble", {RegWrite_out, result_out}, 0);
        idle();
        hilo_rd = 2'b01;
        tick();
        check("flush_hi_kept", result_out, m_hi);
        hilo_rd = 2'b10;
        tick();
        check("flush_lo_kept", result_out, m_lo);

        idle();
        md_op = 3'd3; registro_1 = 32'd100; registro_2 = 32'd7;
        tick();
        idle();
        flush = 1;
        for (int i = 0; i < 5; i++) tick();
        check("busy_under_flush", md_busy, 1);
        flush = 0;
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            tick();
        end
        check("flush_div_done", md_busy, 0);
        hilo_rd = 2'b10;
        tick();
        check("flush_div_lo", result_out, 14);
        hilo_rd = 2'b01;
        tick();
        check("flush_div_hi", result_out, 2);

        idle();
        md_op = 3'd3; registro_1 = 32'd1000; registro_2 = 32'd3;
        tick();
        idle();
        for (int i = 0; i < 5; i++) tick();
        check("mid_div_busy", md_busy, 1);
        reset = 1; RegWrite_in = 1; MemWrite_in = 1;
        tick();
        check("rst_mid_busy", md_busy, 0);
        check("rst_mid_out", {RegWrite_out, MemWrite_out, result_out}, 0);
        reset = 0;
        idle();
        hilo_rd = 2'b10;
        #1;
        check("rst_mflo_nostall", md_stall, 0);
        tick();
        check("rst_lo_zero", result_out, 0);
        hilo_rd = 2'b01;
        tick();
        check("rst_hi_zero", result_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
